// File: rtl/mmio_pkg.sv
// mmio_bridge shared types: region decode, I/O offsets, read-return select.
package mmio_pkg;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_UNMAPPED,
    RGN_IO
  } rgn_e;

  localparam logic [2:0] IO_UART = 3'd0;
  localparam logic [2:0] IO_CLK  = 3'd4;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_IO
  } sel_e;

  function automatic rgn_e rgn_of(input logic [1:0] hi);
    rgn_e r;
    r = RGN_IO;
    unique case (1'b1)
      !hi[1]:       r = RGN_RAM;
      hi == 2'b10:  r = RGN_UNMAPPED;
      default:      r = RGN_IO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU bus, RAM port and UART side-band bundle for mmio_bridge.
interface mmio_bridge_if #(
  parameter int RAM_AW = 17
);
  logic [31:0]       cpu_a;
  logic [7:0]        cpu_dout;
  logic              cpu_wr;
  logic [7:0]        cpu_din;
  logic              io_buffer_full;
  logic [RAM_AW-1:0] ram_a;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_pop;
  logic              tx_full;
  logic              tx_push;
  logic [7:0]        tx_data;
  logic              program_done;
  logic              tx_overflow;

  modport slave (
    input  cpu_a, cpu_dout, cpu_wr,
    input  ram_rdata, rx_valid, rx_data, tx_full,
    output cpu_din, io_buffer_full,
    output ram_a, ram_we, ram_wdata,
    output rx_pop, tx_push, tx_data,
    output program_done, tx_overflow
  );

  modport master (
    output cpu_a, cpu_dout, cpu_wr,
    output ram_rdata, rx_valid, rx_data, tx_full,
    input  cpu_din, io_buffer_full,
    input  ram_a, ram_we, ram_wdata,
    input  rx_pop, tx_push, tx_data,
    input  program_done, tx_overflow
  );
endinterface

// File: rtl/mmio_tx_fifo.sv
// Circular byte FIFO for UART output; almost-full leaves one slot of slack.
module mmio_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       afull
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P1 = AW'(1);
  localparam logic [AW:0] C1 = (AW+1)'(1);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF = (AW+1)'(DEPTH - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + P1;
      if (pop) head <= head + P1;
      case ({push, pop})
        2'b10:   count <= count + C1;
        2'b01:   count <= count - C1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[head];
  assign empty = (count == '0);
  assign full  = (count == C_FULL);
  assign afull = (count >= C_AF);

endmodule

// File: rtl/mmio_bridge.sv
// CPU MMIO decode to RAM, UART and cycle counter/halt register.
// Define MMIO_CLK_SNAPSHOT_EN for coherent 32-bit counter reads.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RAM_AW   = 17
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  mmio_bridge_if.slave bus
);
  rgn_e       rgn;
  logic [2:0] off;
  logic       is_ram, is_io;
  logic       uart_rd, clk_rd, halt_wr;
  logic       wr_tx, drain, accept, drop;
  logic       full, empty, afull;
  logic [7:0] head;
  logic [7:0] clk_byte;
  logic [7:0] io_next;
  logic [7:0] io_q;
  sel_e       sel_next, sel_q;
  logic [31:0] cyc;
  logic       done_q, ovf_q;
  logic       unused_a;

  assign rgn    = rgn_of(bus.cpu_a[17:16]);
  assign off    = bus.cpu_a[2:0];
  assign is_ram = (rgn == RGN_RAM);
  assign is_io  = (rgn == RGN_IO);

  assign uart_rd = is_io && off == IO_UART && !bus.cpu_wr;
  assign clk_rd  = is_io && off[2] && !bus.cpu_wr;
  assign halt_wr = is_io && off == IO_CLK && bus.cpu_wr;

  assign bus.ram_a     = bus.cpu_a[RAM_AW-1:0];
  assign bus.ram_wdata = bus.cpu_dout;
  assign bus.ram_we    = bus.cpu_wr && is_ram && rdy_in;
  assign bus.rx_pop    = rdy_in && uart_rd && bus.rx_valid;

  // Zero bytes are never queued; a full FIFO still accepts if it drains now.
  assign wr_tx = rdy_in && is_io && off == IO_UART
              && bus.cpu_wr && bus.cpu_dout != 8'h00;
  assign drain  = rdy_in && !empty && !bus.tx_full;
  assign accept = wr_tx && (!full || drain);
  assign drop   = wr_tx && full && !drain;

  mmio_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk  (clk_in),
    .rst  (rst_in),
    .push (accept),
    .pop  (drain),
    .din  (bus.cpu_dout),
    .dout (head),
    .full (full),
    .empty(empty),
    .afull(afull)
  );

  assign bus.tx_push        = drain;
  assign bus.tx_data        = head;
  assign bus.io_buffer_full = afull;

`ifdef MMIO_CLK_SNAPSHOT_EN
  logic [31:0] snap;
  logic [7:0]  unused_snap;
  assign unused_snap = snap[7:0];
  assign clk_byte = (off[1:0] == 2'd0) ? cyc[7:0]
                  : snap[{off[1:0], 3'b000} +: 8];
`else
  assign clk_byte = cyc[{off[1:0], 3'b000} +: 8];
`endif

  always_comb begin
    io_next = 8'h00;
    unique case (1'b1)
      uart_rd: io_next = bus.rx_valid ? bus.rx_data : 8'h00;
      clk_rd:  io_next = clk_byte;
      default: io_next = 8'h00;
    endcase
  end

  assign sel_next = bus.cpu_wr ? SEL_ZERO
                  : is_ram     ? SEL_RAM
                  : is_io      ? SEL_IO
                  :              SEL_ZERO;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc    <= '0;
      sel_q  <= SEL_ZERO;
      io_q   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef MMIO_CLK_SNAPSHOT_EN
      snap   <= '0;
`endif
    end else if (rdy_in) begin
      cyc   <= cyc + 32'd1;
      sel_q <= sel_next;
      io_q  <= io_next;
      if (halt_wr) done_q <= 1'b1;
      if (drop) ovf_q <= 1'b1;
`ifdef MMIO_CLK_SNAPSHOT_EN
      if (clk_rd && off[1:0] == 2'd0) snap <= cyc;
`endif
    end
  end

  assign bus.cpu_din      = (sel_q == SEL_RAM) ? bus.ram_rdata : io_q;
  assign bus.program_done = done_q;
  assign bus.tx_overflow  = ovf_q;
  assign unused_a         = ^bus.cpu_a[31:18];

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: read-return and TX byte queues.
// Honours MMIO_CLK_SNAPSHOT_EN for counter-read expectations.
module tb_mmio_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  mmio_bridge_if #(.RAM_AW(17)) bus ();

  mmio_bridge #(.TX_DEPTH(4), .RAM_AW(17)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus)
  );

  logic [7:0] mem [0:131071];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_a] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_a];
  end

  // Reference cycle count; equals the DUT counter between edges.
  logic [31:0] mt;
  always @(posedge clk) begin
    if (rst) mt <= 32'd0;
    else if (rdy) mt <= mt + 32'd1;
  end

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } rd_t;
  rd_t        rd_q[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.tx_push) begin
      if (tx_q.size() == 0)
        chk("tx_extra", 32'(bus.tx_data), 32'h100);
      else
        chk("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
    end
  end

  task automatic step();
    rd_t r;
    @(posedge clk);
    #1;
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      chk(r.tag, 32'(bus.cpu_din), 32'(r.v));
    end
  endtask

  task automatic drv(input logic w, input logic [31:0] a,
                     input logic [7:0] d);
    bus.cpu_wr   = w;
    bus.cpu_a    = a;
    bus.cpu_dout = d;
  endtask

  task automatic idle();
    drv(1'b0, 32'h20000, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input string tag,
                    input logic [7:0] v);
    drv(1'b0, a, 8'h00);
    rd_q.push_back('{tag, v});
    step();
    idle();
  endtask

  task automatic rd_any(input logic [31:0] a);
    drv(1'b0, a, 8'h00);
    step();
    idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    drv(1'b1, a, d);
    step();
    idle();
  endtask

  task automatic tx(input logic [7:0] d, input logic keep);
    if (keep) tx_q.push_back(d);
    wr(32'h30000, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s;
    idle();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_full  = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_din", 32'(bus.cpu_din), 0);
    chk("rst_ibf", 32'(bus.io_buffer_full), 0);
    chk("rst_done", 32'(bus.program_done), 0);
    chk("rst_ovf", 32'(bus.tx_overflow), 0);
    chk("rst_push", 32'(bus.tx_push), 0);
    chk("rst_pop", 32'(bus.rx_pop), 0);
    chk("rst_we", 32'(bus.ram_we), 0);
    tx(8'h41, 1'b1);
    chk("first_push", 32'(bus.tx_push), 1);
    chk("first_data", 32'(bus.tx_data), 32'h41);
    step();

    drv(1'b1, 32'h00123, 8'h5A);
    #1;
    chk("ram_we", 32'(bus.ram_we), 1);
    chk("ram_a", 32'(bus.ram_a), 32'h123);
    chk("ram_wdata", 32'(bus.ram_wdata), 32'h5A);
    step();
    idle();
    drv(1'b1, 32'h1FFFF, 8'hC3);
    #1;
    chk("ram_a_hi", 32'(bus.ram_a), 32'h1FFFF);
    step();
    idle();
    drv(1'b1, 32'h20123, 8'h99);
    #1;
    chk("unm_we", 32'(bus.ram_we), 0);
    step();
    idle();
    rd(32'h00123, "ram_rd", 8'h5A);
    rd(32'h1FFFF, "ram_rd_hi", 8'hC3);
    rd(32'h20123, "unm_rd", 8'h00);

    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h7E;
    rd(32'h30001, "io_gap", 8'h00);
    drv(1'b0, 32'h30000, 8'h00);
    #1;
    chk("rx_pop", 32'(bus.rx_pop), 1);
    rd_q.push_back('{"rx_rd", 8'h7E});
    step();
    idle();
    #1;
    chk("rx_pop_idle", 32'(bus.rx_pop), 0);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h55;
    drv(1'b0, 32'h30000, 8'h00);
    #1;
    chk("rx_nopop", 32'(bus.rx_pop), 0);
    rd_q.push_back('{"rx_empty", 8'h00});
    step();
    idle();

    s = mt;
    rd(32'h30004, "cyc_b0", s[7:0]);
`ifdef MMIO_CLK_SNAPSHOT_EN
    rd(32'h30005, "cyc_b1", s[15:8]);
    rd(32'h30007, "cyc_b3", s[31:24]);
`else
    s = mt;
    rd(32'h30005, "cyc_b1", s[15:8]);
    s = mt;
    rd(32'h30007, "cyc_b3", s[31:24]);
`endif

    wr(32'h30004, 8'h00);
    chk("halt", 32'(bus.program_done), 1);
    repeat (3) step();
    chk("halt_sticky", 32'(bus.program_done), 1);

    bus.tx_full = 1'b1;
    tx(8'h31, 1'b1);
    tx(8'h32, 1'b1);
    chk("bp_2", 32'(bus.io_buffer_full), 0);
    tx(8'h00, 1'b0);
    chk("bp_zero", 32'(bus.io_buffer_full), 0);
    tx(8'h33, 1'b1);
    chk("bp_3", 32'(bus.io_buffer_full), 1);
    tx(8'h34, 1'b1);
    chk("ovf_pre", 32'(bus.tx_overflow), 0);
    tx(8'h35, 1'b0);
    chk("ovf_set", 32'(bus.tx_overflow), 1);

    bus.tx_full = 1'b0;
    tx_q.push_back(8'h36);
    drv(1'b1, 32'h30000, 8'h36);
    #1;
    chk("drain0_push", 32'(bus.tx_push), 1);
    chk("drain0", 32'(bus.tx_data), 32'h31);
    step();
    idle();
    chk("full_drain_acc", 32'(bus.io_buffer_full), 1);
    chk("drain1", 32'(bus.tx_data), 32'h32);
    step();
    chk("drain2", 32'(bus.tx_data), 32'h33);
    step();
    chk("drain3", 32'(bus.tx_data), 32'h34);
    step();
    chk("drain4", 32'(bus.tx_data), 32'h36);
    step();
    chk("drain_done", 32'(bus.tx_push), 0);
    chk("ovf_sticky", 32'(bus.tx_overflow), 1);

    bus.tx_full = 1'b1;
    tx(8'h51, 1'b1);
    tx(8'h52, 1'b1);
    tx(8'h53, 1'b1);
    bus.tx_full = 1'b0;
    step();
    rdy = 1'b0;
    drv(1'b1, 32'h00055, 8'h11);
    #1;
    chk("frz_we", 32'(bus.ram_we), 0);
    chk("frz_push", 32'(bus.tx_push), 0);
    bus.rx_valid = 1'b1;
    drv(1'b0, 32'h30000, 8'h00);
    #1;
    chk("frz_pop", 32'(bus.rx_pop), 0);
    repeat (5) step();
    chk("frz_push_end", 32'(bus.tx_push), 0);
    bus.rx_valid = 1'b0;
    idle();
    rdy = 1'b1;
    #1;
    chk("frz_resume", 32'(bus.tx_push), 1);
    chk("frz_head", 32'(bus.tx_data), 32'h52);
    s = mt;
    rd(32'h30004, "frz_cyc", s[7:0]);
    repeat (2) step();

    bus.tx_full = 1'b1;
    tx(8'h61, 1'b0);
    tx(8'h62, 1'b0);
    tx(8'h63, 1'b0);
    chk("pre_rst_ibf", 32'(bus.io_buffer_full), 1);
    drv(1'b0, 32'h00123, 8'h00);
    rst = 1'b1;
    rd_q.push_back('{"rst_rd", 8'h00});
    step();
    idle();
    rst = 1'b0;
    chk("mid_rst_ibf", 32'(bus.io_buffer_full), 0);
    chk("mid_rst_done", 32'(bus.program_done), 0);
    chk("mid_rst_ovf", 32'(bus.tx_overflow), 0);
    bus.tx_full = 1'b0;
    #1;
    chk("mid_rst_push", 32'(bus.tx_push), 0);

    force dut.cyc = 32'hFFFF_FFF0;
    step();
    release dut.cyc;
`ifdef MMIO_CLK_SNAPSHOT_EN
    rd_any(32'h30004);
`endif
    rd(32'h30007, "wrap_pre", 8'hFF);
    repeat (20) step();
`ifdef MMIO_CLK_SNAPSHOT_EN
    rd(32'h30007, "snap_hold", 8'hFF);
    rd_any(32'h30004);
`endif
    rd(32'h30007, "wrap_b3", 8'h00);
    rd(32'h30006, "wrap_b2", 8'h00);
    rd(32'h30005, "wrap_b1", 8'h00);

    step();
    chk("tx_q_left", 32'(tx_q.size()), 0);
    chk("rd_q_left", 32'(rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
